i2s_rx_deserializer: RTL and testbench

- Downstream consumer of the I2S clock divider outputs.
- Runs in the mclk domain. Detects sclk rising edges and lrclk transitions, then shifts the serial ADC data line into left and right words.
- Delivers one stereo frame per lrclk period over a valid/ready handshake to the effects pipeline.
- Standard I2S framing: lrclk low = left, high = right; MSB arrives one sclk after each lrclk transition.

---
 rtl/i2s_rx_deserializer.sv | 144 ++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: samples sclk/lrclk/sdata in the mclk domain and emits L/R frames on valid/ready.
// Define I2S_RX_SYNC_EN to pass sclk, lrclk and sdata through two-flop synchronizers first.
module i2s_rx_deserializer #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic              sdata,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              locked_o,
    output logic              overflow_o
);
    localparam int CNT_W = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

    typedef enum logic {SYNC, RUN} state_t;
    state_t state, state_nx;

    logic sclk_s, lrclk_s, sdata_s;

`ifdef I2S_RX_SYNC_EN
    logic [1:0] sclk_q, lrclk_q, sdata_q;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sclk_q  <= '0;
            lrclk_q <= '0;
            sdata_q <= '0;
        end else begin
            sclk_q  <= {sclk_q[0], sclk};
            lrclk_q <= {lrclk_q[0], lrclk};
            sdata_q <= {sdata_q[0], sdata};
        end
    end

    assign sclk_s  = sclk_q[1];
    assign lrclk_s = lrclk_q[1];
    assign sdata_s = sdata_q[1];
`else
    assign sclk_s  = sclk;
    assign lrclk_s = lrclk;
    assign sdata_s = sdata;
`endif

    logic              sclk_d;
    logic              ws_prev;
    logic              chan;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] left_hold;
    logic              left_ok;

    logic              rise;
    logic              ws_chg;
    logic              take;
    logic              done;
    logic              short_slot;
    logic              emit;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] sh_nx;

    always_comb begin
        state_nx   = state;
        rise       = sclk_s & ~sclk_d;
        ws_chg     = lrclk_s ^ ws_prev;
        take       = (state == RUN) && (bit_cnt < FULL);
        cnt_inc    = bit_cnt + CNT_W'(1);
        sh_nx      = {shreg[DATA_W-2:0], sdata_s};
        done       = rise && take && (cnt_inc == FULL);
        // Slot ended on this rise without collecting a full word
        short_slot = rise && ws_chg && (state == RUN) &&
                     ((take ? cnt_inc : bit_cnt) < FULL);
        emit       = done && chan && left_ok;
        if (rise && (state == SYNC) && ws_chg)
            state_nx = RUN;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst)
            state <= SYNC;
        else
            state <= state_nx;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sclk_d    <= 1'b0;
            ws_prev   <= 1'b0;
            chan      <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            left_hold <= '0;
            left_ok   <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            if (rise) begin
                ws_prev <= lrclk_s;
                if (take) begin
                    shreg   <= sh_nx;
                    bit_cnt <= cnt_inc;
                end
                if (done && !chan) begin
                    left_hold <= sh_nx;
                    left_ok   <= 1'b1;
                end
                if (emit || short_slot)
                    left_ok <= 1'b0;
                if (ws_chg) begin
                    chan    <= lrclk_s;
                    bit_cnt <= '0;
                end
                if ((state == SYNC) && ws_chg)
                    locked_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            left_o     <= '0;
            right_o    <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else if (emit && (!valid_o || ready_i)) begin
            left_o  <= left_hold;
            right_o <= sh_nx;
            valid_o <= 1'b1;
        end else begin
            if (valid_o && ready_i)
                valid_o <= 1'b0;
            // Held frame not yet taken: the new one is lost
            if (emit)
                overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Self-checking bench for i2s_rx_deserializer: 24/32 and 16/16 instances driven by a bit-clock model.
`timescale 1ps/1ps
module tb_i2s_rx_deserializer;
    localparam int MCLK_P = 4428;
`ifdef I2S_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic mclk = 1'b0;
    logic rst  = 1'b1;

    logic a_sclk = 1'b0, a_lrclk = 1'b0, a_sdata = 1'b0, a_ready = 1'b1;
    logic [23:0] a_left, a_right;
    logic a_valid, a_locked, a_ovf;

    logic b_sclk = 1'b0, b_lrclk = 1'b0, b_sdata = 1'b0, b_ready = 1'b1;
    logic [15:0] b_left, b_right;
    logic b_valid, b_locked, b_ovf;

    int errors = 0;
    int checks = 0;
    int pcnt = 0;
    int tgt = 0;
    logic carry = 1'b0;
    int rcomp_pc = 0, vrise_pc = 0;
    int a_vhigh = 0, a_xfers = 0, b_xfers = 0;
    int v0, x0;
    logic [47:0] qa[$];
    logic [31:0] qb[$];

    i2s_rx_deserializer #(.DATA_W(24), .SLOT_W(32)) dut (
        .mclk(mclk), .rst(rst), .sclk(a_sclk), .lrclk(a_lrclk), .sdata(a_sdata),
        .left_o(a_left), .right_o(a_right), .valid_o(a_valid), .ready_i(a_ready),
        .locked_o(a_locked), .overflow_o(a_ovf)
    );

    i2s_rx_deserializer #(.DATA_W(16), .SLOT_W(16)) dut16 (
        .mclk(mclk), .rst(rst), .sclk(b_sclk), .lrclk(b_lrclk), .sdata(b_sdata),
        .left_o(b_left), .right_o(b_right), .valid_o(b_valid), .ready_i(b_ready),
        .locked_o(b_locked), .overflow_o(b_ovf)
    );

    always #(MCLK_P / 2) mclk = ~mclk;
    always @(posedge mclk) pcnt <= pcnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_a();
        logic [47:0] f;
        logic vprev;
        vprev = 1'b0;
        forever begin
            @(negedge mclk);
            #1;
            if (a_valid && !vprev) vrise_pc = pcnt;
            if (a_valid) a_vhigh++;
            vprev = a_valid;
            if (a_valid && a_ready) begin
                a_xfers++;
                chk("a_sb_pending", 32'(qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    f = qa.pop_front();
                    chk("a_left", 32'(a_left), 32'(f[47:24]));
                    chk("a_right", 32'(a_right), 32'(f[23:0]));
                end
            end
        end
    endtask

    task automatic mon_b();
        logic [31:0] f;
        forever begin
            @(negedge mclk);
            #1;
            if (b_valid && b_ready) begin
                b_xfers++;
                chk("b_sb_pending", 32'(qb.size() > 0), 1);
                if (qb.size() > 0) begin
                    f = qb.pop_front();
                    chk("b_left", 32'(b_left), 32'(f[31:16]));
                    chk("b_right", 32'(b_right), 32'(f[15:0]));
                end
            end
        end
    endtask

    // One sclk period: 4 mclk low then 4 mclk high; lrclk/sdata change while sclk is low
    task automatic bitp(input logic ws, input logic d, input logic mark);
        @(negedge mclk);
        if (tgt == 0) begin
            a_sclk = 1'b0; a_lrclk = ws; a_sdata = d;
        end else begin
            b_sclk = 1'b0; b_lrclk = ws; b_sdata = d;
        end
        repeat (4) @(negedge mclk);
        if (tgt == 0) a_sclk = 1'b1;
        else b_sclk = 1'b1;
        if (mark) rcomp_pc = pcnt;
        repeat (3) @(negedge mclk);
    endtask

    // Each period carries the previous bit, so the MSB lands one sclk after the lrclk edge
    task automatic slot(input logic ch, input logic [31:0] word, input int dw, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bitp(ch, carry, ch && (i == dw));
            carry = (i < dw) ? word[dw-1-i] : 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int dw, input int sw);
        slot(1'b0, l, dw, sw);
        slot(1'b1, r, dw, sw);
    endtask

    task automatic settle();
        repeat (4) @(negedge mclk);
        #2;
    endtask

    initial begin
        fork
            mon_a();
            mon_b();
        join_none

        repeat (3) @(negedge mclk);
        #1;
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_locked", 32'(a_locked), 0);
        chk("rst_overflow", 32'(a_ovf), 0);
        chk("rst_left", 32'(a_left), 0);
        chk("rst_right", 32'(a_right), 0);
        chk("rst_b_valid", 32'(b_valid), 0);
        @(negedge mclk);
        rst = 1'b0;

        // Power-up: first frame only locks, second is delivered
        slot(1'b0, 32'h123456, 24, 32);
        chk("s1_locked_before_edge", 32'(a_locked), 0);
        slot(1'b1, 32'hABCDEF, 24, 32);
        chk("s1_locked_after_edge", 32'(a_locked), 1);
        chk("s1_no_early_frame", a_xfers, 0);
        qa.push_back({24'h123456, 24'hABCDEF});
        v0 = a_vhigh;
        x0 = a_xfers;
        frame(32'h123456, 32'hABCDEF, 24, 32);
        settle();
        chk("s1_latency", vrise_pc - rcomp_pc, LAT);
        chk("s1_valid_width", a_vhigh - v0, 1);
        chk("s1_xfers", a_xfers - x0, 1);

        // Reset in the middle of a right slot
        x0 = a_xfers;
        slot(1'b0, 32'h111111, 24, 32);
        slot(1'b1, 32'h222222, 24, 12);
        @(negedge mclk);
        rst = 1'b1;
        repeat (3) @(negedge mclk);
        #1;
        chk("s2_rst_valid", 32'(a_valid), 0);
        chk("s2_rst_locked", 32'(a_locked), 0);
        @(negedge mclk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) bitp(1'b1, 1'b1, 1'b0);
        carry = 1'b0;
        chk("s2_no_partial_frame", a_xfers - x0, 0);
        qa.push_back({24'h333333, 24'h444444});
        frame(32'h333333, 32'h444444, 24, 32);
        settle();
        chk("s2_xfers", a_xfers - x0, 1);
        chk("s2_relocked", 32'(a_locked), 1);

        // Short left slot: that frame is dropped silently
        x0 = a_xfers;
        slot(1'b0, 32'h555555, 24, 10);
        slot(1'b1, 32'h666666, 24, 32);
        chk("s3_short_dropped", a_xfers - x0, 0);
        qa.push_back({24'h777777, 24'h888888});
        frame(32'h777777, 32'h888888, 24, 32);
        settle();
        chk("s3_xfers", a_xfers - x0, 1);
        chk("s3_overflow", 32'(a_ovf), 0);

        // Backpressure: three frames while ready is low
        a_ready = 1'b0;
        x0 = a_xfers;
        frame(32'h000001, 32'h0000A1, 24, 32);
        chk("s4_valid_held", 32'(a_valid), 1);
        chk("s4_left_f1", 32'(a_left), 32'h000001);
        chk("s4_overflow_f1", 32'(a_ovf), 0);
        frame(32'h000002, 32'h0000A2, 24, 32);
        chk("s4_overflow_f2", 32'(a_ovf), 1);
        chk("s4_left_f2", 32'(a_left), 32'h000001);
        frame(32'h000003, 32'h0000A3, 24, 32);
        chk("s4_left_f3", 32'(a_left), 32'h000001);
        chk("s4_right_f3", 32'(a_right), 32'h0000A1);
        qa.push_back({24'h000001, 24'h0000A1});
        a_ready = 1'b1;
        settle();
        chk("s4_xfers", a_xfers - x0, 1);
        chk("s4_valid_low", 32'(a_valid), 0);
        chk("s4_overflow_sticky", 32'(a_ovf), 1);

        // SLOT_W == DATA_W: LSB arrives on the lrclk transition rise
        tgt = 1;
        carry = 1'b0;
        x0 = b_xfers;
        frame(32'h8001, 32'h7FFE, 16, 16);
        qb.push_back({16'h8001, 16'h7FFE});
        frame(32'h8001, 32'h7FFE, 16, 16);
        bitp(1'b0, carry, 1'b0);
        bitp(1'b0, 1'b0, 1'b0);
        settle();
        chk("s5_xfers", b_xfers - x0, 1);
        chk("s5_locked", 32'(b_locked), 1);
        chk("s5_overflow", 32'(b_ovf), 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
